// File: rtl/serial_input_conditioner.sv
// Pushbutton front end for the LED shift register: synchronise, debounce, detect presses,
// generate the shift strobe and present one latched serial bit per strobe.
module serial_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_PERIOD     = 50000000
) (
    input  logic CLK_50M,
    input  logic RST,
    input  logic BTN_SOUTH,
    output logic btn_level,
    output logic press_pulse,
    output logic press_pending,
    output logic tick_out,
    output logic bit_out
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TICK_W = $clog2(TICK_PERIOD);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [DB_W-1:0]        db_cnt;
    logic                   level_d;
    logic [TICK_W-1:0]      tick_cnt;
    logic                   tick_hit;

    assign sync     = sync_ff[SYNC_STAGES-1];
    assign tick_hit = (tick_cnt == TICK_W'(TICK_PERIOD - 1));

    // Synchroniser chain for the asynchronous button input.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], BTN_SOUTH};
        end
    end

    // Debounce: level follows sync only after it differs for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else if (sync == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt    <= '0;
            btn_level <= sync;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Rising-edge detect on the debounced level; pulse lags the level by one cycle.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            level_d     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            level_d     <= btn_level;
            press_pulse <= btn_level & ~level_d;
        end
    end

    // Free-running period counter producing a registered single-cycle strobe.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            tick_cnt <= '0;
            tick_out <= 1'b0;
        end else if (tick_hit) begin
            tick_cnt <= '0;
            tick_out <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            tick_out <= 1'b0;
        end
    end

    // A press arriving on the strobe edge is consumed directly, so it is never also left pending.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            press_pending <= 1'b0;
            bit_out       <= 1'b0;
        end else if (tick_hit) begin
            bit_out       <= press_pending | press_pulse;
            press_pending <= 1'b0;
        end else begin
            press_pending <= press_pending | press_pulse;
        end
    end

endmodule

// File: tb/tb_serial_input_conditioner.sv
// Directed bench for serial_input_conditioner with short debounce and tick periods.
// A second instance with a longer period covers several presses inside one period.
module tb_serial_input_conditioner;

    logic clk;
    logic rst;
    logic btn;
    logic btn2;
    logic btn_level, press_pulse, press_pending, tick_out, bit_out;
    logic btn_level2, press_pulse2, press_pending2, tick2, bit2;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    serial_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TICK_PERIOD    (10)
    ) dut (
        .CLK_50M      (clk),
        .RST          (rst),
        .BTN_SOUTH    (btn),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .press_pending(press_pending),
        .tick_out     (tick_out),
        .bit_out      (bit_out)
    );

    serial_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TICK_PERIOD    (40)
    ) dut_long (
        .CLK_50M      (clk),
        .RST          (rst),
        .BTN_SOUTH    (btn2),
        .btn_level    (btn_level2),
        .press_pulse  (press_pulse2),
        .press_pending(press_pending2),
        .tick_out     (tick2),
        .bit_out      (bit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // One clock, then sample; both strobes are checked against the cycle count every step.
    task automatic tick_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("tick", tick_out, 32'((cyc % 10) == 0));
        chk("tick2", tick2, 32'((cyc % 40) == 0));
    endtask

    task automatic wait_phase(input int period, input int phase);
        while ((cyc % period) != phase) tick_step();
    endtask

    int npulse;

    initial begin
        rst  = 1'b1;
        btn  = 1'b0;
        btn2 = 1'b0;

        // 1: reset, then strobe every 10 cycles with bit_out held at 0
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", btn_level, 0);
        chk("rst_pulse", press_pulse, 0);
        chk("rst_pending", press_pending, 0);
        chk("rst_tick", tick_out, 0);
        chk("rst_bit", bit_out, 0);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick_step();
            chk("idle_bit", bit_out, 0);
        end

        // 2: 3-cycle glitch never reaches the debounced level
        btn = 1'b1;
        repeat (3) tick_step();
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_step();
            chk("glitch_level", btn_level, 0);
            chk("glitch_pulse", press_pulse, 0);
            chk("glitch_pending", press_pending, 0);
        end

        // 3: held press, level after 6 cycles, consumed by next strobe only once
        wait_phase(10, 0);                       // cyc 40
        btn = 1'b1;
        repeat (5) tick_step();                  // 45
        chk("hold_level_early", btn_level, 0);
        tick_step();                             // 46
        chk("hold_level", btn_level, 1);
        chk("hold_pulse_pre", press_pulse, 0);
        tick_step();                             // 47
        chk("hold_pulse", press_pulse, 1);
        chk("hold_pending_pre", press_pending, 0);
        tick_step();                             // 48
        chk("hold_pulse_end", press_pulse, 0);
        chk("hold_pending", press_pending, 1);
        tick_step();                             // 49
        chk("hold_bit_pre", bit_out, 0);
        tick_step();                             // 50
        chk("hold_bit", bit_out, 1);
        chk("hold_pending_clr", press_pending, 0);
        repeat (9) tick_step();                  // 59
        chk("hold_bit_stable", bit_out, 1);
        tick_step();                             // 60
        chk("hold_bit_next", bit_out, 0);
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_step();                         // 61..70
            chk("release_pulse", press_pulse, 0);
            if (cyc == 65) chk("release_level_early", btn_level, 1);
            if (cyc == 66) chk("release_level", btn_level, 0);
        end

        // 4: three presses inside one 40-cycle period collapse to a single 1
        wait_phase(40, 0);                       // cyc 80
        npulse = 0;
        for (int p = 0; p < 3; p++) begin
            btn2 = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick_step();
                npulse += int'(press_pulse2);
            end
            btn2 = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick_step();
                npulse += int'(press_pulse2);
            end
        end                                      // cyc 110
        chk("multi_pulses", 32'(npulse), 3);
        repeat (9) tick_step();                  // 119
        chk("multi_pending", press_pending2, 1);
        chk("multi_bit_pre", bit2, 0);
        tick_step();                             // 120
        chk("multi_bit", bit2, 1);
        chk("multi_pending_clr", press_pending2, 0);
        repeat (39) tick_step();                 // 159
        chk("multi_bit_stable", bit2, 1);
        tick_step();                             // 160
        chk("multi_bit_next", bit2, 0);

        // 5: press pulse coincident with the strobe edge
        wait_phase(10, 2);                       // cyc 162
        btn = 1'b1;
        repeat (6) tick_step();                  // 168
        chk("coin_level", btn_level, 1);
        tick_step();                             // 169
        chk("coin_pulse", press_pulse, 1);
        chk("coin_pending_pre", press_pending, 0);
        chk("coin_bit_pre", bit_out, 0);
        tick_step();                             // 170
        chk("coin_bit", bit_out, 1);
        chk("coin_pending", press_pending, 0);
        btn = 1'b0;
        repeat (9) begin
            tick_step();                         // 171..179
            chk("coin_pending_hold", press_pending, 0);
        end
        chk("coin_bit_stable", bit_out, 1);

        // 6: reset with a pending press and the period counter at 7
        btn = 1'b1;
        tick_step();                             // 180
        chk("coin_bit_next", bit_out, 0);
        repeat (6) tick_step();                  // 186
        chk("rst6_pulse", press_pulse, 1);
        tick_step();                             // 187
        chk("rst6_pending_pre", press_pending, 1);
        rst = 1'b1;
        btn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst6_pending", press_pending, 0);
        chk("rst6_bit", bit_out, 0);
        chk("rst6_level", btn_level, 0);
        chk("rst6_tick", tick_out, 0);
        rst = 1'b0;
        cyc = 0;
        repeat (20) tick_step();
        chk("rst6_final_pending", press_pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
